// File: rtl/projeto_pkg.sv
// User-code classes, function limits and FSM states shared by the function arbiter.
// Codes are 3 bits wide; wider user buses compare against zero-extended values.
package projeto_pkg;

    localparam logic [2:0] INVALIDO_A = 3'b000;
    localparam logic [2:0] INVALIDO_B = 3'b100;
    localparam logic [2:0] ADMIN      = 3'b101;
    localparam logic [2:0] PILOTO     = 3'b111;

    localparam int FUNC_PILOTO    = 5;
    localparam int MAX_FUNC_ADMIN = 6;
    localparam int MAX_FUNC_COMUM = 4;

    typedef enum logic [1:0] {IDLE, EXEC, PILOTO_ST} state_t;

    typedef enum logic [1:0] {CL_INVALIDO, CL_COMUM, CL_ADMIN, CL_PILOTO} classe_t;

endpackage

// File: rtl/verificador_de_permissao_param.sv
// Per-channel permission check: classifies the user code and masks a forbidden function to 0.
// Purely combinational.
module verificador_de_permissao_param
    import projeto_pkg::*;
#(
    parameter int USER_W = 3,
    parameter int FUNC_W = 3
) (
    input  logic [USER_W-1:0] user,
    input  logic [FUNC_W-1:0] func,
    output logic [FUNC_W-1:0] func_ok,
    output classe_t           classe
);

    logic permitido;

    always_comb begin
        classe = CL_COMUM;
        if (user == USER_W'(INVALIDO_A) || user == USER_W'(INVALIDO_B)) begin
            classe = CL_INVALIDO;
        end else if (user == USER_W'(ADMIN)) begin
            classe = CL_ADMIN;
        end else if (user == USER_W'(PILOTO)) begin
            classe = CL_PILOTO;
        end
    end

    always_comb begin
        permitido = 1'b0;
        case (classe)
            CL_ADMIN:  permitido = (func != '0) && (func <= FUNC_W'(MAX_FUNC_ADMIN));
            CL_COMUM:  permitido = (func != '0) && (func <= FUNC_W'(MAX_FUNC_COMUM));
            CL_PILOTO: permitido = (func == FUNC_W'(FUNC_PILOTO));
            default:   permitido = 1'b0;
        endcase
    end

    assign func_ok = permitido ? func : '0;

endmodule

// File: rtl/arbitro_de_funcionalidades.sv
// Latches per-channel function requests and grants one execution slot (admin first, then round-robin) for HOLD_CYCLES.
// Request edge to Func_Out is 2 cycles; ARBITRO_PREEMPCAO_ADMIN_EN lets admin requests preempt non-admin execution.
module arbitro_de_funcionalidades
    import projeto_pkg::*;
#(
    parameter int N_USERS     = 2,
    parameter int USER_W      = 3,
    parameter int FUNC_W      = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int IDX_W       = (N_USERS > 1) ? $clog2(N_USERS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_USERS*USER_W-1:0] User,
    input  logic [N_USERS*FUNC_W-1:0] Func,
    output logic [FUNC_W-1:0]         Func_Out,
    output logic [USER_W-1:0]         User_Out,
    output logic [IDX_W-1:0]          Grant_Idx,
    output logic [N_USERS-1:0]        Grant,
    output logic                      Busy,
    output logic [N_USERS-1:0]        Pending,
    output logic                      Piloto
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [USER_W-1:0]  user_ch [N_USERS];
    logic [FUNC_W-1:0]  perm    [N_USERS];
    classe_t            classe  [N_USERS];
    logic [N_USERS-1:0] live, adm_mask, valid_mask, pil_mask;

    for (genvar i = 0; i < N_USERS; i++) begin : g_canal
        assign user_ch[i] = User[i*USER_W +: USER_W];

        verificador_de_permissao_param #(
            .USER_W (USER_W),
            .FUNC_W (FUNC_W)
        ) u_verif (
            .user    (user_ch[i]),
            .func    (Func[i*FUNC_W +: FUNC_W]),
            .func_ok (perm[i]),
            .classe  (classe[i])
        );

        assign live[i]       = (perm[i] != '0);
        assign adm_mask[i]   = (classe[i] == CL_ADMIN);
        assign valid_mask[i] = (classe[i] != CL_INVALIDO);
        assign pil_mask[i]   = (classe[i] == CL_PILOTO);
    end

    logic piloto_cond;
    assign piloto_cond = (valid_mask != '0) && ((valid_mask & ~pil_mask) == '0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               adm_q, adm_d;
    logic [FUNC_W-1:0]  func_out_d;
    logic [USER_W-1:0]  user_out_d;
    logic [IDX_W-1:0]   grant_idx_d;
    logic [N_USERS-1:0] grant_d;
    logic               busy_d, piloto_d;
    logic               do_grant, limpa;

    logic [FUNC_W-1:0]  prev_q      [N_USERS];
    logic [FUNC_W-1:0]  pend_func_q [N_USERS];
    logic               armed_q;

    // A request being withdrawn this cycle is not eligible; ptr_q is the first channel to scan.
    logic [N_USERS-1:0] admin_pend, cand;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;

    always_comb begin
        admin_pend = Pending & live & adm_mask;
        cand       = (admin_pend != '0) ? admin_pend : (Pending & live);
        sel_vld    = 1'b0;
        sel_idx    = '0;
        for (int k = 0; k < N_USERS; k++) begin
            logic [IDX_W:0] c;
            c = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (c >= (IDX_W+1)'(N_USERS)) c = c - (IDX_W+1)'(N_USERS);
            if (!sel_vld && cand[c[IDX_W-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = c[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        adm_d       = adm_q;
        func_out_d  = Func_Out;
        user_out_d  = User_Out;
        grant_idx_d = Grant_Idx;
        grant_d     = Grant;
        busy_d      = Busy;
        piloto_d    = Piloto;
        do_grant    = 1'b0;
        limpa       = 1'b0;

        case (state_q)
            IDLE: begin
                if (piloto_cond) begin
                    state_d    = PILOTO_ST;
                    piloto_d   = 1'b1;
                    func_out_d = FUNC_W'(FUNC_PILOTO);
                end else if (sel_vld) begin
                    do_grant = 1'b1;
                end
            end
            EXEC: begin
                if (classe[Grant_Idx] == CL_INVALIDO) begin
                    limpa = 1'b1;
                end
`ifdef ARBITRO_PREEMPCAO_ADMIN_EN
                else if (!adm_q && admin_pend != '0) begin
                    do_grant = 1'b1;
                end
`endif
                else if (cnt_q == '0) begin
                    limpa = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PILOTO_ST: begin
                if (!piloto_cond) limpa = 1'b1;
            end
            default: limpa = 1'b1;
        endcase

        if (limpa) begin
            state_d     = IDLE;
            func_out_d  = '0;
            user_out_d  = '0;
            grant_idx_d = '0;
            grant_d     = '0;
            busy_d      = 1'b0;
            piloto_d    = 1'b0;
            adm_d       = 1'b0;
        end

        if (do_grant) begin
            state_d          = EXEC;
            cnt_d            = CNT_W'(HOLD_CYCLES - 1);
            func_out_d       = pend_func_q[sel_idx];
            user_out_d       = user_ch[sel_idx];
            grant_idx_d      = sel_idx;
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
            busy_d           = 1'b1;
            adm_d            = (classe[sel_idx] == CL_ADMIN);
            ptr_d            = (int'(sel_idx) == N_USERS - 1) ? '0 : sel_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            adm_q     <= 1'b0;
            Func_Out  <= '0;
            User_Out  <= '0;
            Grant_Idx <= '0;
            Grant     <= '0;
            Busy      <= 1'b0;
            Piloto    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            adm_q     <= adm_d;
            Func_Out  <= func_out_d;
            User_Out  <= user_out_d;
            Grant_Idx <= grant_idx_d;
            Grant     <= grant_d;
            Busy      <= busy_d;
            Piloto    <= piloto_d;
        end
    end

    // The first clock after reset only samples prev_q, so a request held through reset is not re-latched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Pending <= '0;
            armed_q <= 1'b0;
            for (int i = 0; i < N_USERS; i++) begin
                prev_q[i]      <= '0;
                pend_func_q[i] <= '0;
            end
        end else begin
            armed_q <= 1'b1;
            if (state_q != PILOTO_ST) begin
                for (int i = 0; i < N_USERS; i++) begin
                    prev_q[i] <= perm[i];
                    if (armed_q && live[i] && perm[i] != prev_q[i]) begin
                        Pending[i]     <= 1'b1;
                        pend_func_q[i] <= perm[i];
                    end else if (!live[i] || (do_grant && int'(sel_idx) == i)) begin
                        Pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_arbitro_de_funcionalidades.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model of the arbiter.
module tb_arbitro_de_funcionalidades;

    localparam int N  = 2;
    localparam int UW = 3;
    localparam int FW = 3;
    localparam int H  = 4;
    localparam int IW = 1;
`ifdef ARBITRO_PREEMPCAO_ADMIN_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic [N*UW-1:0] User;
    logic [N*FW-1:0] Func;
    logic [FW-1:0]   Func_Out;
    logic [UW-1:0]   User_Out;
    logic [IW-1:0]   Grant_Idx;
    logic [N-1:0]    Grant;
    logic            Busy;
    logic [N-1:0]    Pending;
    logic            Piloto;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    arbitro_de_funcionalidades #(
        .N_USERS     (N),
        .USER_W      (UW),
        .FUNC_W      (FW),
        .HOLD_CYCLES (H),
        .IDX_W       (IW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .User      (User),
        .Func      (Func),
        .Func_Out  (Func_Out),
        .User_Out  (User_Out),
        .Grant_Idx (Grant_Idx),
        .Grant     (Grant),
        .Busy      (Busy),
        .Pending   (Pending),
        .Piloto    (Piloto)
    );

    // Reference model: pending is the latched function code (0 = none), m_left counts visible cycles left.
    int m_pf [N];
    int m_prev [N];
    int m_p [N];
    int m_u [N];
    bit m_armed, m_busy, m_pil, m_adm;
    int m_left, m_next, m_gi, m_fo, m_uo;

    function automatic int permitted(int u, int f);
        case (u)
            0, 4:    return 0;
            5:       return (f >= 1 && f <= 6) ? f : 0;
            7:       return (f == 5) ? 5 : 0;
            default: return (f >= 1 && f <= 4) ? f : 0;
        endcase
    endfunction

    function automatic int pick(bit only_adm);
        for (int k = 0; k < N; k++) begin
            int c = (m_next + k) % N;
            if (m_pf[c] != 0 && m_p[c] != 0 && (!only_adm || m_u[c] == 5)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pf[i] = 0;
            m_prev[i] = 0;
        end
        m_armed = 0; m_busy = 0; m_pil = 0; m_adm = 0;
        m_left = 0; m_next = 0; m_gi = 0; m_fo = 0; m_uo = 0;
    endtask

    task automatic model_step();
        int win, gf, nvalid, npil;
        bit drop, any_adm, pcond, was_pil;
        win = -1; drop = 0; any_adm = 0; nvalid = 0; npil = 0; was_pil = m_pil;
        for (int i = 0; i < N; i++) begin
            m_u[i] = int'(User[i*UW +: UW]);
            m_p[i] = permitted(m_u[i], int'(Func[i*FW +: FW]));
            if (m_u[i] != 0 && m_u[i] != 4) nvalid++;
            if (m_u[i] == 7) npil++;
            if (m_pf[i] != 0 && m_p[i] != 0 && m_u[i] == 5) any_adm = 1;
        end
        pcond = (nvalid > 0) && (nvalid == npil);
        if (m_pil) begin
            drop = !pcond;
        end else if (!m_busy) begin
            if (pcond) begin
                m_pil = 1;
                m_fo  = 5;
            end else begin
                win = pick(any_adm);
            end
        end else if (m_u[m_gi] == 0 || m_u[m_gi] == 4) begin
            drop = 1;
        end else if (PREEMPT && !m_adm && any_adm) begin
            win = pick(1'b1);
        end else begin
            m_left--;
            drop = (m_left == 0);
        end
        gf = (win >= 0) ? m_pf[win] : 0;
        if (!was_pil) begin
            for (int i = 0; i < N; i++) begin
                if (m_armed && m_p[i] != 0 && m_p[i] != m_prev[i]) m_pf[i] = m_p[i];
                else if (m_p[i] == 0 || i == win) m_pf[i] = 0;
                m_prev[i] = m_p[i];
            end
        end
        m_armed = 1;
        if (drop) begin
            m_busy = 0; m_pil = 0; m_adm = 0;
            m_fo = 0; m_uo = 0; m_gi = 0;
        end
        if (win >= 0) begin
            m_busy = 1; m_left = H; m_fo = gf; m_uo = m_u[win]; m_gi = win;
            m_adm  = (m_u[win] == 5);
            m_next = (win + 1) % N;
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) model_reset();
        else     model_step();
    end

    task automatic idle_all();
        User = {3'b001, 3'b001};
        Func = '0;
        repeat (H + 3) @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if ({Func_Out, User_Out, Grant_Idx, Grant, Busy, Pending, Piloto} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {Func_Out, User_Out, Grant_Idx, Grant, Busy, Pending, Piloto});
        end
        RST = 0;
        @(negedge CLK);
        checks++;
        if ({Busy, Pending, Piloto} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b required=0", {Busy, Pending, Piloto});
        end
    endtask

    task automatic test_single();
        int bc;
        idle_all();
        Func = {3'b000, 3'b001};
        @(negedge CLK);
        checks++;
        if (Pending !== 2'b01 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL single_latch pending=%b busy=%b required 01/0", Pending, Busy);
        end
        @(negedge CLK);
        checks++;
        if (Func_Out !== 3'd1 || Grant !== 2'b01 || Busy !== 1'b1 || User_Out !== 3'b001) begin
            failures++;
            $display("FAIL single_grant func=%0d grant=%b busy=%b user=%b required 1/01/1/001", Func_Out, Grant, Busy, User_Out);
        end
        bc = 1;
        repeat (6) begin
            @(negedge CLK);
            if (Busy === 1'b1) bc++;
        end
        checks++;
        if (bc != H) begin
            failures++;
            $display("FAIL single_hold busy_cycles=%0d required=%0d", bc, H);
        end
        checks++;
        if (Func_Out !== '0 || Grant !== '0) begin
            failures++;
            $display("FAIL single_release func=%0d grant=%b required 0/00", Func_Out, Grant);
        end
    endtask

    task automatic test_priority();
        idle_all();
        User = {3'b101, 3'b001};
        Func = {3'b010, 3'b010};
        @(negedge CLK);
        checks++;
        if (Pending !== 2'b11) begin
            failures++;
            $display("FAIL prio_latch pending=%b required=11", Pending);
        end
        @(negedge CLK);
        checks++;
        if (Grant !== 2'b10 || Func_Out !== 3'd2 || User_Out !== 3'b101 || Grant_Idx !== 1'b1) begin
            failures++;
            $display("FAIL prio_admin grant=%b func=%0d user=%b idx=%0d required 10/2/101/1", Grant, Func_Out, User_Out, Grant_Idx);
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Pending !== 2'b01) begin
            failures++;
            $display("FAIL prio_idle_gap busy=%b pending=%b required 0/01", Busy, Pending);
        end
        @(negedge CLK);
        checks++;
        if (Grant !== 2'b01 || Func_Out !== 3'd2 || User_Out !== 3'b001) begin
            failures++;
            $display("FAIL prio_second grant=%b func=%0d user=%b required 01/2/001", Grant, Func_Out, User_Out);
        end
    endtask

    task automatic test_piloto();
        idle_all();
        User = {3'b111, 3'b111};
        Func = {3'b101, 3'b101};
        @(negedge CLK);
        checks++;
        if (Piloto !== 1'b1 || Func_Out !== 3'd5) begin
            failures++;
            $display("FAIL piloto_enter piloto=%b func=%0d required 1/5", Piloto, Func_Out);
        end
        @(negedge CLK);
        checks++;
        if (Piloto !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL piloto_hold piloto=%b busy=%b required 1/0", Piloto, Busy);
        end
        User = {3'b001, 3'b111};
        @(negedge CLK);
        checks++;
        if (Piloto !== 1'b0 || Func_Out !== '0) begin
            failures++;
            $display("FAIL piloto_exit piloto=%b func=%0d required 0/0", Piloto, Func_Out);
        end
    endtask

    task automatic test_sem_permissao();
        idle_all();
        User = {3'b001, 3'b100};
        Func = {3'b110, 3'b001};
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if (Pending !== 2'b00 || Busy !== 1'b0) begin
                failures++;
                $display("FAIL no_permission pending=%b busy=%b required 00/0", Pending, Busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_all();
        Func = {3'b000, 3'b011};
        repeat (3) @(negedge CLK);
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_busy busy=%b required=1", Busy);
        end
        #2 RST = 1;
        #1;
        checks++;
        if ({Func_Out, User_Out, Grant_Idx, Grant, Busy, Pending, Piloto} !== '0) begin
            failures++;
            $display("FAIL rst_mid_async got=%h required=0", {Func_Out, User_Out, Grant_Idx, Grant, Busy, Pending, Piloto});
        end
        @(negedge CLK);
        RST = 0;
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if (Busy !== 1'b0 || Pending !== 2'b00) begin
                failures++;
                $display("FAIL rst_no_regrant busy=%b pending=%b required 0/00", Busy, Pending);
            end
        end
        Func = '0;
        @(negedge CLK);
        Func = {3'b000, 3'b011};
        repeat (2) @(negedge CLK);
        checks++;
        if (Func_Out !== 3'd3 || Grant !== 2'b01) begin
            failures++;
            $display("FAIL rst_retoggle func=%0d grant=%b required 3/01", Func_Out, Grant);
        end
    endtask

    task automatic test_preempt();
        idle_all();
        User = {3'b101, 3'b001};
        Func = {3'b000, 3'b011};
        repeat (2) @(negedge CLK);
        checks++;
        if (Func_Out !== 3'd3 || Grant !== 2'b01) begin
            failures++;
            $display("FAIL preempt_base func=%0d grant=%b required 3/01", Func_Out, Grant);
        end
        Func = {3'b110, 3'b011};
        @(negedge CLK);
        checks++;
        if (Pending !== 2'b10) begin
            failures++;
            $display("FAIL preempt_pending pending=%b required=10", Pending);
        end
        @(negedge CLK);
`ifdef ARBITRO_PREEMPCAO_ADMIN_EN
        checks++;
        if (Grant !== 2'b10 || Func_Out !== 3'd6 || Pending !== 2'b00) begin
            failures++;
            $display("FAIL preempt_switch grant=%b func=%0d pending=%b required 10/6/00", Grant, Func_Out, Pending);
        end
`else
        checks++;
        if (Grant !== 2'b01 || Func_Out !== 3'd3) begin
            failures++;
            $display("FAIL preempt_wait grant=%b func=%0d required 01/3", Grant, Func_Out);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL preempt_gap busy=%b required=0", Busy);
        end
        @(negedge CLK);
        checks++;
        if (Grant !== 2'b10 || Func_Out !== 3'd6) begin
            failures++;
            $display("FAIL preempt_after grant=%b func=%0d required 10/6", Grant, Func_Out);
        end
`endif
    endtask

    task automatic test_random();
        logic [FW+UW+IW+2*N+1:0] got, expv;
        logic [N-1:0] exp_pend, exp_grant;
        RST = 1;
        User = '0;
        Func = '0;
        @(negedge CLK);
        RST = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) exp_pend[i] = (m_pf[i] != 0);
            exp_grant = m_busy ? N'(1 << m_gi) : '0;
            got  = {Func_Out, User_Out, Grant_Idx, Grant, Busy, Pending, Piloto};
            expv = {FW'(m_fo), UW'(m_uo), IW'(m_gi), exp_grant, m_busy, exp_pend, m_pil};
            checks++;
            if (got !== expv) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h required=%h", cyc, got, expv);
            end
            if ($urandom_range(0, 40) == 0) begin
                User = {3'b111, 3'b111};
                Func = {3'b101, 3'b101};
            end else begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 5) == 0) User[i*UW +: UW] = UW'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0)
                        Func[i*FW +: FW] = ($urandom_range(0, 2) == 0) ? '0 : FW'($urandom_range(1, 7));
                end
            end
        end
    endtask

    initial begin
        RST  = 1;
        User = '0;
        Func = '0;
        test_reset();
        test_single();
        test_priority();
        test_piloto();
        test_sem_permissao();
        test_reset_mid();
        test_preempt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
